intdiv_qconv: RTL

Sequential on-the-fly converter for the integer divider's quotient path. It accepts the divider's SD2 quotient digits serially, MSB first, one per valid cycle, and keeps the running quotient Q together with Q-1 and Q+1 in two's complement. When intdiv_adj reports its decision (padj/seladj), the block selects the corrected final quotient. It sits downstream of the digit-recurrence core and the final-adjust logic and feeds the result register.

---
 rtl/intdiv_pkg.sv | 43 ++++
 rtl/intdiv_otf_step.sv | 49 ++++
 rtl/intdiv_qconv.sv | 117 +++++++++++
 3 files changed

// File: rtl/intdiv_pkg.sv
// Shared definitions for the integer divider quotient path.
//   - SD2 digit encodings as produced by the digit-recurrence core
//   - sign and on/off constants
//   - controller state enumeration used by intdiv_qconv
//   - sd2_decode(): maps a raw 2-bit SD2 code onto its digit value
package intdiv_pkg;

  // SD2 digit codes. +1 has two encodings; both are treated identically.
  localparam logic [1:0] NEG1   = 2'b11;
  localparam logic [1:0] ZERO   = 2'b00;
  localparam logic [1:0] POS1_1 = 2'b01;
  localparam logic [1:0] POS1_2 = 2'b10;

  localparam logic NEGATIVE = 1'b1;
  localparam logic POSITIVE = 1'b0;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONV     = 2'd1,
    WAIT_ADJ = 2'd2
  } state_e;

  // Decoded digit value, independent of which +1 encoding was used.
  typedef enum logic [1:0] {
    SD_ZERO = 2'd0,
    SD_POS  = 2'd1,
    SD_NEG  = 2'd2
  } sd2_val_e;

  function automatic sd2_val_e sd2_decode(input logic [1:0] code);
    sd2_val_e val;
    case (code)
      NEG1:           val = SD_NEG;
      POS1_1, POS1_2: val = SD_POS;
      default:        val = SD_ZERO;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/intdiv_otf_step.sv
// One on-the-fly conversion step (combinational).
// Given the running quotient Q with its neighbours QM = Q-1 and QP = Q+1
// (all mod 2^N) and the next SD2 digit, produce the updated triple.
// Every result is a left shift of one of the three inputs with a fixed
// LSB appended, so no carry chain is needed.
// Ports:
//   i_q, i_qm, i_qp : current Q, Q-1, Q+1
//   i_dig           : SD2 digit (11=-1, 00=0, 01/10=+1)
//   o_q, o_qm, o_qp : next Q, Q-1, Q+1
module intdiv_otf_step
  import intdiv_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_qm,
  input  logic [N-1:0] i_qp,
  input  logic [1:0]   i_dig,
  output logic [N-1:0] o_q,
  output logic [N-1:0] o_qm,
  output logic [N-1:0] o_qp
);

  sd2_val_e w_val;
  assign w_val = sd2_decode(i_dig);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned; that is what keeps this block free of latches.
    o_q  = {i_q[N-2:0],  1'b0};
    o_qm = {i_qm[N-2:0], 1'b1};
    o_qp = {i_q[N-2:0],  1'b1};
    case (w_val)
      SD_POS: begin
        o_q  = {i_q[N-2:0],  1'b1};
        o_qm = {i_q[N-2:0],  1'b0};
        o_qp = {i_qp[N-2:0], 1'b0};
      end
      SD_NEG: begin
        // 2Q-1 = 2(Q-1)+1, so the new Q comes from the old QM.
        o_q  = {i_qm[N-2:0], 1'b1};
        o_qm = {i_qm[N-2:0], 1'b0};
        o_qp = {i_q[N-2:0],  1'b0};
      end
      default: ;  // SD_ZERO: defaults above
    endcase
  end

endmodule

// File: rtl/intdiv_qconv.sv
// Sequential on-the-fly quotient converter for the integer divider.
// Accepts N SD2 quotient digits MSB first, tracks Q, Q-1 and Q+1, then
// picks the corrected quotient when the final-adjust decision arrives.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_start       : begin a conversion (IDLE only)
//   i_dig_valid   : i_dig carries a digit (CONV only)
//   i_dig         : SD2 digit
//   i_adj_valid   : i_padj/i_seladj valid (WAIT_ADJ only)
//   i_padj        : 1 = Q+1, 0 = Q-1 (when i_seladj = 0)
//   i_seladj      : 1 = take Q unchanged
//   o_busy        : high in CONV and WAIT_ADJ
//   o_q_valid     : one-cycle pulse when o_q_out is updated
//   o_q_out       : final two's-complement quotient, held until next result
module intdiv_qconv
  import intdiv_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_dig_valid,
  input  logic [1:0]   i_dig,
  input  logic         i_adj_valid,
  input  logic         i_padj,
  input  logic         i_seladj,
  output logic         o_busy,
  output logic         o_q_valid,
  output logic [N-1:0] o_q_out
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N - 1);

  state_e           r_state;
  logic [N-1:0]     r_q;
  logic [N-1:0]     r_qm;
  logic [N-1:0]     r_qp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_q_valid;
  logic [N-1:0]     r_q_out;

  logic [N-1:0]     w_q_nxt;
  logic [N-1:0]     w_qm_nxt;
  logic [N-1:0]     w_qp_nxt;

  intdiv_otf_step #(.N(N)) u_step (
    .i_q  (r_q),
    .i_qm (r_qm),
    .i_qp (r_qp),
    .i_dig(i_dig),
    .o_q  (w_q_nxt),
    .o_qm (w_qm_nxt),
    .o_qp (w_qp_nxt)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_q       <= '0;
      r_qm      <= '1;
      r_qp      <= N'(1);
      r_cnt     <= '0;
      r_busy    <= OFF;
      r_q_valid <= OFF;
      r_q_out   <= '0;
    end else begin
      r_q_valid <= OFF;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_q     <= '0;
            r_qm    <= '1;
            r_qp    <= N'(1);
            r_cnt   <= '0;
            r_busy  <= ON;
            r_state <= CONV;
          end
        end
        CONV: begin
          if (i_dig_valid) begin
            r_q   <= w_q_nxt;
            r_qm  <= w_qm_nxt;
            r_qp  <= w_qp_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_DIG) begin
              r_state <= WAIT_ADJ;
            end
          end
        end
        WAIT_ADJ: begin
          if (i_adj_valid) begin
            if (i_seladj)    r_q_out <= r_q;
            else if (i_padj) r_q_out <= r_qp;
            else             r_q_out <= r_qm;
            r_q_valid <= ON;
            r_busy    <= OFF;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= OFF;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_q_valid = r_q_valid;
  assign o_q_out   = r_q_out;

endmodule
